ans_enc_ctrl: RTL

ANS_ENC_CTRL -- requirements
Module: ans_enc_ctrl

---
 rtl/ans_enc_ctrl_pkg.sv | 28 ++
 rtl/ans_enc_ctrl_freq_table.sv | 79 +++++++
 rtl/ans_enc_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ans_enc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ans_enc_ctrl_pkg
// Shared constants and the controller state encoding for the ANS encoder
// control slice. Both the controller top and the frequency table import it.
//   SYM_WIDTH   : symbol / output word width
//   CNT_WIDTH   : per-symbol frequency count width
//   NSYM        : alphabet size
//   STATE_WIDTH : width of the controller state register
// ---------------------------------------------------------------------------
package ans_enc_ctrl_pkg;

    localparam int SYM_WIDTH   = 4;
    localparam int CNT_WIDTH   = 4;
    localparam int NSYM        = 2 ** SYM_WIDTH;
    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE      = 3'd0,
        ST_PREFIX    = 3'd1,
        ST_INIT      = 3'd2,
        ST_RUN       = 3'd3,
        ST_CHECK     = 3'd4,
        ST_FLUSH_REQ = 3'd5,
        ST_FLUSH_OUT = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

endpackage

// File: rtl/ans_enc_ctrl_freq_table.sv
// ---------------------------------------------------------------------------
// ans_freq_table
// Frequency table with a sequential prefix-sum engine.
//   clk, rst_n          : clock, synchronous active-low reset (clears table)
//   we_i/waddr_i/wcnt_i : count write port
//   pfx_step_i          : process one table entry this cycle
//   pfx_last_o          : the entry processed this cycle is the last one
//   pfx_sum_o           : running sum including the current entry
//   raddr_i             : read address
//   rcnt_o / rcum_o     : count and cumulative count at raddr_i
//   total_o             : sum of all counts from the last prefix pass
// ---------------------------------------------------------------------------
module ans_freq_table
    import ans_enc_ctrl_pkg::*;
#(
    parameter int SYM_WIDTH = ans_enc_ctrl_pkg::SYM_WIDTH,
    parameter int CNT_WIDTH = ans_enc_ctrl_pkg::CNT_WIDTH,
    parameter int NSYM      = 2 ** SYM_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we_i,
    input  logic [SYM_WIDTH-1:0]           waddr_i,
    input  logic [CNT_WIDTH-1:0]           wcnt_i,
    input  logic                           pfx_step_i,
    output logic                           pfx_last_o,
    output logic [SYM_WIDTH+CNT_WIDTH-1:0] pfx_sum_o,
    input  logic [SYM_WIDTH-1:0]           raddr_i,
    output logic [CNT_WIDTH-1:0]           rcnt_o,
    output logic [SYM_WIDTH+CNT_WIDTH-1:0] rcum_o,
    output logic [SYM_WIDTH+CNT_WIDTH-1:0] total_o
);

    localparam int ACC_WIDTH = SYM_WIDTH + CNT_WIDTH;

    logic [CNT_WIDTH-1:0] cnt_q [NSYM];
    logic [ACC_WIDTH-1:0] cum_q [NSYM];
    logic [ACC_WIDTH-1:0] total_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [SYM_WIDTH-1:0] idx_q;
    logic [ACC_WIDTH-1:0] sum_d;

    // Exclusive prefix: cum[i] receives the sum of entries before i.
    assign sum_d      = acc_q + ACC_WIDTH'(cnt_q[idx_q]);
    assign pfx_last_o = (idx_q == SYM_WIDTH'(NSYM - 1));
    assign pfx_sum_o  = sum_d;
    assign rcnt_o     = cnt_q[raddr_i];
    assign rcum_o     = cum_q[raddr_i];
    assign total_o    = total_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSYM; i++) begin
                cnt_q[i] <= '0;
                cum_q[i] <= '0;
            end
            total_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            if (we_i) begin
                cnt_q[waddr_i] <= wcnt_i;
            end
            if (pfx_step_i) begin
                cum_q[idx_q] <= acc_q;
                if (pfx_last_o) begin
                    // Wrap so the next pass starts clean.
                    total_q <= sum_d;
                    acc_q   <= '0;
                    idx_q   <= '0;
                end else begin
                    acc_q <= sum_d;
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ans_enc_ctrl.sv
// ---------------------------------------------------------------------------
// ans_enc_ctrl
// Control FSM sitting between a symbol stream and an rANS encoder core.
//   clk, rst_n                  : clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_cnt     : frequency-table write (accepted in IDLE)
//   start, flush                : begin message / end of message
//   busy, flush_done, err       : status (flush_done pulses, err is sticky)
//   sym/sym_vld/sym_rdy         : upstream symbol stream
//   enc_count/enc_cum/enc_total : encoder operands for the held symbol
//   enc_in_vld/enc_in_rdy       : encoder input handshake
//   enc_ena                     : encoder enable
//   enc_out/enc_out_vld/_rdy    : encoder output words
//   out_data/out_vld/out_rdy    : downstream word stream
// ---------------------------------------------------------------------------
module ans_enc_ctrl
    import ans_enc_ctrl_pkg::*;
#(
    parameter int SYM_WIDTH = ans_enc_ctrl_pkg::SYM_WIDTH,
    parameter int CNT_WIDTH = ans_enc_ctrl_pkg::CNT_WIDTH,
    parameter int NSYM      = 2 ** SYM_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_we,
    input  logic [SYM_WIDTH-1:0]           cfg_addr,
    input  logic [CNT_WIDTH-1:0]           cfg_cnt,
    input  logic                           start,
    input  logic                           flush,
    output logic                           busy,
    output logic                           flush_done,
    output logic                           err,
    input  logic [SYM_WIDTH-1:0]           sym,
    input  logic                           sym_vld,
    output logic                           sym_rdy,
    output logic [CNT_WIDTH-1:0]           enc_count,
    output logic [SYM_WIDTH+CNT_WIDTH-1:0] enc_cum,
    output logic [SYM_WIDTH+CNT_WIDTH-1:0] enc_total,
    output logic                           enc_in_vld,
    input  logic                           enc_in_rdy,
    output logic                           enc_ena,
    input  logic [SYM_WIDTH-1:0]           enc_out,
    input  logic                           enc_out_vld,
    output logic                           enc_out_rdy,
    output logic [SYM_WIDTH-1:0]           out_data,
    output logic                           out_vld,
    input  logic                           out_rdy
);

    localparam int ACC_WIDTH = SYM_WIDTH + CNT_WIDTH;

    state_t               state_q, state_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [CNT_WIDTH-1:0] enc_count_q, enc_count_d;
    logic [ACC_WIDTH-1:0] enc_cum_q, enc_cum_d;
    logic                 err_q, err_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 wait_q, wait_d;
    logic [SYM_WIDTH-1:0] fword_q, fword_d;

    logic                 tbl_we;
    logic                 pfx_step;
    logic                 pfx_last;
    logic [ACC_WIDTH-1:0] pfx_sum;
    logic [CNT_WIDTH-1:0] tbl_rcnt;
    logic [ACC_WIDTH-1:0] tbl_rcum;
    logic                 sym_hs;
    logic                 enc_hs;
    logic                 flush_take;

    ans_freq_table #(
        .SYM_WIDTH (SYM_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .NSYM      (NSYM)
    ) u_tbl (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (tbl_we),
        .waddr_i    (cfg_addr),
        .wcnt_i     (cfg_cnt),
        .pfx_step_i (pfx_step),
        .pfx_last_o (pfx_last),
        .pfx_sum_o  (pfx_sum),
        .raddr_i    (sym),
        .rcnt_o     (tbl_rcnt),
        .rcum_o     (tbl_rcum),
        .total_o    (enc_total)
    );

    assign tbl_we   = cfg_we && (state_q == ST_IDLE);
    assign pfx_step = (state_q == ST_PREFIX);

    // New symbols are refused once a flush is pending so that nothing is
    // latched that the flush would then strand in the hold register.
    assign sym_rdy    = (state_q == ST_RUN) && !hold_vld_q && !flush && !flush_pend_q;
    assign sym_hs     = sym_rdy && sym_vld;
    assign enc_in_vld = (state_q == ST_RUN) && hold_vld_q;
    assign enc_hs     = enc_in_vld && enc_in_rdy;
    assign flush_take = (flush || flush_pend_q) && !hold_vld_q && !enc_out_vld;

    assign busy       = (state_q != ST_IDLE);
    assign flush_done = (state_q == ST_DONE);
    assign err        = err_q;
    assign enc_ena    = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_CHECK);
    assign enc_count  = enc_count_q;
    assign enc_cum    = enc_cum_q;

    // Output word path: live pass-through while encoding, captured flush
    // word while draining.
    always_comb begin
        out_data    = '0;
        out_vld     = 1'b0;
        enc_out_rdy = 1'b0;
        case (state_q)
            ST_RUN, ST_CHECK: begin
                out_data    = enc_out;
                out_vld     = enc_out_vld;
                enc_out_rdy = out_rdy;
            end
            ST_FLUSH_OUT: begin
                out_data    = fword_q;
                out_vld     = 1'b1;
                enc_out_rdy = out_rdy;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        hold_vld_d   = hold_vld_q;
        enc_count_d  = enc_count_q;
        enc_cum_d    = enc_cum_q;
        err_d        = err_q;
        flush_pend_d = flush_pend_q;
        wait_d       = wait_q;
        fword_d      = fword_q;
        case (state_q)
            ST_IDLE: begin
                hold_vld_d   = 1'b0;
                flush_pend_d = 1'b0;
                if (start) begin
                    err_d   = 1'b0;
                    state_d = ST_PREFIX;
                end
            end
            ST_PREFIX: begin
                if (pfx_last) begin
                    if (pfx_sum == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
            end
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (sym_hs) begin
                    if (tbl_rcnt == '0) begin
                        err_d = 1'b1;
                    end else begin
                        hold_vld_d  = 1'b1;
                        enc_count_d = tbl_rcnt;
                        enc_cum_d   = tbl_rcum;
                    end
                end else if (enc_hs) begin
                    state_d = ST_CHECK;
                end else if (flush_take) begin
                    flush_pend_d = 1'b0;
                    wait_d       = 1'b0;
                    state_d      = ST_FLUSH_REQ;
                end
            end
            ST_CHECK: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                // A word here means the encoder renormalised instead of
                // consuming the symbol, so it stays held for another try.
                if (!enc_out_vld) begin
                    hold_vld_d = 1'b0;
                end
                state_d = ST_RUN;
            end
            ST_FLUSH_REQ: begin
                if (enc_out_vld) begin
                    fword_d = enc_out;
                    state_d = ST_FLUSH_OUT;
                end else if (wait_q) begin
                    state_d = ST_DONE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            ST_FLUSH_OUT: begin
                if (out_rdy) begin
                    wait_d  = 1'b0;
                    state_d = ST_FLUSH_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_vld_q   <= 1'b0;
            enc_count_q  <= '0;
            enc_cum_q    <= '0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            wait_q       <= 1'b0;
            fword_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_vld_q   <= hold_vld_d;
            enc_count_q  <= enc_count_d;
            enc_cum_q    <= enc_cum_d;
            err_q        <= err_d;
            flush_pend_q <= flush_pend_d;
            wait_q       <= wait_d;
            fword_q      <= fword_d;
        end
    end

endmodule
